jk_bank_scheduler: RTL and testbench

- Round-robin scheduler that shares one bank of WIDTH JK-style storage bits among NREQ requesters.
- Each requester issues commands of the form {J, K, bit index} over a valid/ready handshake.
- One command is granted per cycle and applied to the addressed bit with JK semantics (hold/clear/set/toggle).
- Sits between control agents and the shared flag/state register bank; the bank contents are exported as q.

---
 rtl/jk_bank_scheduler.sv | 130 +++++++++++++
 tb/tb_jk_bank_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_scheduler.sv
// jk_bank_scheduler: round-robin arbiter that shares one bank of JK bits among NREQ requesters.
// Each accepted command {J, K, idx} applies hold/clear/set/toggle to bit idx of the bank.
// Optional build macro JKB_PRIO0_EN: requester 0 becomes a fixed high-priority lane whose
// grants leave the round-robin pointer untouched.
module jk_bank_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 3,
    parameter int unsigned GIDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_j,
    input  logic [NREQ-1:0]      req_k,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [WIDTH-1:0]     q,
    output logic                 grant_valid,
    output logic [GIDW-1:0]      grant_id,
    output logic                 err_oor
);

    logic [WIDTH-1:0] r_q;
    logic [GIDW-1:0]  r_rr_ptr;
    logic [GIDW-1:0]  r_grant_id;
    logic             r_grant_valid;
    logic             r_err_oor;

    logic             w_found;
    int unsigned      w_win;
    int unsigned      w_best_dist;
    int unsigned      w_dist;
    logic [IDXW-1:0]  w_idx;
    logic             w_j;
    logic             w_k;
    logic             w_oor;
    logic [WIDTH-1:0] w_q_d;
    logic [GIDW-1:0]  w_rr_d;

    // Arbitration: the valid requester with the smallest rotated distance from rr_ptr wins.
    always_comb begin
        w_found     = 1'b0;
        w_win       = 0;
        w_best_dist = NREQ;
        w_dist      = 0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            // r_rr_ptr is always < NREQ, so the sum never underflows.
            w_dist = (r + NREQ - 32'(r_rr_ptr)) % NREQ;
            if (req_valid[r] && (w_dist < w_best_dist)) begin
                w_found     = 1'b1;
                w_win       = r;
                w_best_dist = w_dist;
            end
        end
`ifdef JKB_PRIO0_EN
        if (req_valid[0]) begin
            w_found = 1'b1;
            w_win   = 0;
        end
`endif
    end

    // Command mux and one-hot ready for the winning requester.
    always_comb begin
        w_idx     = '0;
        w_j       = 1'b0;
        w_k       = 1'b0;
        req_ready = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            if (w_win == r) begin
                w_idx        = req_idx[r*IDXW +: IDXW];
                w_j          = req_j[r];
                w_k          = req_k[r];
                req_ready[r] = w_found && !reset;
            end
        end
        w_oor = (32'(w_idx) >= WIDTH);
    end

    // Next-state: JK update of the addressed bit and round-robin pointer advance.
    always_comb begin
        w_q_d  = r_q;
        w_rr_d = r_rr_ptr;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (w_found && !w_oor && (32'(w_idx) == b)) begin
                case ({w_j, w_k})
                    2'b01:   w_q_d[b] = 1'b0;
                    2'b10:   w_q_d[b] = 1'b1;
                    2'b11:   w_q_d[b] = ~r_q[b];
                    default: w_q_d[b] = r_q[b];
                endcase
            end
        end
        if (w_found) begin
`ifdef JKB_PRIO0_EN
            if (w_win != 0) begin
                w_rr_d = GIDW'((w_win + 1) % NREQ);
            end
`else
            w_rr_d = GIDW'((w_win + 1) % NREQ);
`endif
        end
    end

    // State registers; grant_id keeps the last accepted requester across idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q           <= '0;
            r_rr_ptr      <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_err_oor     <= 1'b0;
        end else begin
            r_q           <= w_q_d;
            r_rr_ptr      <= w_rr_d;
            r_grant_valid <= w_found;
            r_err_oor     <= w_found && w_oor;
            if (w_found) begin
                r_grant_id <= GIDW'(w_win);
            end
        end
    end

    assign q           = r_q;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign err_oor     = r_err_oor;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// tb_jk_bank_scheduler: table vectors, hand-written corner sequences and randomized traffic
// checked against a behavioural model of the scheduler.
module tb_jk_bank_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDXW  = 4;  // wide enough to express out-of-range indices
    localparam int GIDW  = 2;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_j;
    logic [NREQ-1:0]      req_k;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [WIDTH-1:0]     q;
    logic                 grant_valid;
    logic [GIDW-1:0]      grant_id;
    logic                 err_oor;

    jk_bank_scheduler #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .IDXW (IDXW),
        .GIDW (GIDW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_j      (req_j),
        .req_k      (req_k),
        .req_idx    (req_idx),
        .q          (q),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .err_oor    (err_oor)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Requester-side command state.
    bit t_v[NREQ];
    bit t_j[NREQ];
    bit t_k[NREQ];
    int t_idx[NREQ];

    // Reference model state.
    logic [WIDTH-1:0] mq;
    int               mptr;
    logic             mgv;
    int               mgid;
    logic             moor;

    typedef struct packed {
        logic [3:0]  v;
        logic [3:0]  j;
        logic [3:0]  k;
        logic [15:0] idx;
        logic [3:0]  rdy;
        logic [7:0]  q;
        logic        gv;
        logic [1:0]  gid;
        logic        oor;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < NREQ; r++) begin
            req_valid[r]              = t_v[r];
            req_j[r]                  = t_j[r];
            req_k[r]                  = t_k[r];
            req_idx[r*IDXW +: IDXW]   = t_idx[r][IDXW-1:0];
        end
    endtask

    task automatic clear_reqs();
        for (int r = 0; r < NREQ; r++) begin
            t_v[r]   = 1'b0;
            t_j[r]   = 1'b0;
            t_k[r]   = 1'b0;
            t_idx[r] = 0;
        end
    endtask

    task automatic model_reset();
        mq   = '0;
        mptr = 0;
        mgv  = 1'b0;
        mgid = 0;
        moor = 1'b0;
    endtask

    // Winner: requester 0 if the priority lane is enabled and it asks, otherwise the first
    // valid requester found walking upward from the pointer with wrap-around.
    function automatic int model_winner();
`ifdef JKB_PRIO0_EN
        if (t_v[0]) return 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (t_v[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_update(input int w);
        int ix;
        if (w >= 0) begin
            ix = t_idx[w];
            if (ix < WIDTH) begin
                case ({t_j[w], t_k[w]})
                    2'b01:   mq[ix[2:0]] = 1'b0;
                    2'b10:   mq[ix[2:0]] = 1'b1;
                    2'b11:   mq[ix[2:0]] = ~mq[ix[2:0]];
                    default: ;
                endcase
            end
            mgv  = 1'b1;
            mgid = w;
            moor = (ix >= WIDTH);
`ifdef JKB_PRIO0_EN
            if (w != 0) mptr = (w + 1) % NREQ;
`else
            mptr = (w + 1) % NREQ;
`endif
        end else begin
            mgv  = 1'b0;
            moor = 1'b0;
        end
    endtask

    // One cycle, entered and left at a falling edge. Returns the sampled ready and winner.
    task automatic step(output logic [3:0] rdy, output int w);
        logic [3:0] exp_rdy;
        drive();
        #1;
        w       = model_winner();
        exp_rdy = (w < 0) ? 4'b0000 : 4'(1 << w);
        rdy     = req_ready;
        chk("ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        model_update(w);
        #1;
        chk("q", 32'(q), 32'(mq));
        chk("grant_valid", 32'(grant_valid), 32'(mgv));
        chk("grant_id", 32'(grant_id), 32'(mgid));
        chk("err_oor", 32'(err_oor), 32'(moor));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_gv", 32'(grant_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_req(input int r, input bit v, input bit j, input bit k, input int ix);
        t_v[r]   = v;
        t_j[r]   = j;
        t_k[r]   = k;
        t_idx[r] = ix;
    endtask

    initial begin
        logic [3:0] rdy;
        int         w;

        tbl[0] = '{v:4'b0010, j:4'b0010, k:4'b0000, idx:16'h0030, rdy:4'b0010, q:8'h08, gv:1'b1, gid:2'd1, oor:1'b0};
        tbl[1] = '{v:4'b0000, j:4'b0000, k:4'b0000, idx:16'h0000, rdy:4'b0000, q:8'h08, gv:1'b0, gid:2'd1, oor:1'b0};
        tbl[2] = '{v:4'b1000, j:4'b1000, k:4'b1000, idx:16'h9000, rdy:4'b1000, q:8'h08, gv:1'b1, gid:2'd3, oor:1'b1};
        tbl[3] = '{v:4'b0000, j:4'b0000, k:4'b0000, idx:16'h0000, rdy:4'b0000, q:8'h08, gv:1'b0, gid:2'd3, oor:1'b0};
        tbl[4] = '{v:4'b0101, j:4'b0101, k:4'b0101, idx:16'h0505, rdy:4'b0001, q:8'h28, gv:1'b1, gid:2'd0, oor:1'b0};
        tbl[5] = '{v:4'b0100, j:4'b0101, k:4'b0101, idx:16'h0505, rdy:4'b0100, q:8'h08, gv:1'b1, gid:2'd2, oor:1'b0};
        tbl[6] = '{v:4'b0010, j:4'b0000, k:4'b0010, idx:16'h0030, rdy:4'b0010, q:8'h00, gv:1'b1, gid:2'd1, oor:1'b0};
        tbl[7] = '{v:4'b0011, j:4'b0001, k:4'b0000, idx:16'h0077, rdy:4'b0001, q:8'h80, gv:1'b1, gid:2'd0, oor:1'b0};
        tbl[8] = '{v:4'b0010, j:4'b0000, k:4'b0000, idx:16'h0070, rdy:4'b0010, q:8'h80, gv:1'b1, gid:2'd1, oor:1'b0};

        reset = 1'b1;
        clear_reqs();
        drive();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Table vectors: set, idle, out-of-range, same-bit toggles, clear, wrap, hold.
        for (int i = 0; i < 9; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                set_req(r, tbl[i].v[r], tbl[i].j[r], tbl[i].k[r], int'(tbl[i].idx[r*4 +: 4]));
            end
            step(rdy, w);
            chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].q));
            chk($sformatf("tbl%0d_gv", i), 32'(grant_valid), 32'(tbl[i].gv));
            chk($sformatf("tbl%0d_gid", i), 32'(grant_id), 32'(tbl[i].gid));
            chk($sformatf("tbl%0d_oor", i), 32'(err_oor), 32'(tbl[i].oor));
        end

        // Continuous contention from reset.
        clear_reqs();
        do_reset();
`ifdef JKB_PRIO0_EN
        set_req(0, 1'b1, 1'b1, 1'b1, 0);
        set_req(1, 1'b1, 1'b1, 1'b1, 1);
        for (int i = 0; i < 6; i++) begin
            step(rdy, w);
            chk("prio_ready", 32'(rdy), 32'h1);
            chk("prio_gid", 32'(grant_id), 32'h0);
            chk("prio_starved_bit", 32'(q[1]), 32'h0);
        end
`else
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 1'b1, 1'b1, r);
        for (int i = 0; i < 8; i++) begin
            step(rdy, w);
            chk("rr_gid", 32'(grant_id), 32'(i % NREQ));
            if (i == 3) chk("rr_q_after4", 32'(q), 32'h0F);
            if (i == 7) chk("rr_q_after8", 32'(q), 32'h00);
        end
`endif

        // Fill with ones, then hold and clear on bit 2.
        clear_reqs();
        for (int b = 0; b < WIDTH; b++) begin
            set_req(0, 1'b1, 1'b1, 1'b0, b);
            step(rdy, w);
        end
        chk("fill_q", 32'(q), 32'hFF);
        set_req(0, 1'b1, 1'b0, 1'b0, 2);
        step(rdy, w);
        chk("hold_q", 32'(q), 32'hFF);
        set_req(0, 1'b1, 1'b0, 1'b1, 2);
        step(rdy, w);
        chk("clear_q", 32'(q), 32'hFB);

        // Reset during a cycle that would otherwise grant requester 3.
        clear_reqs();
        do_reset();
        foreach (tbl[i]) ;
        set_req(2, 1'b1, 1'b1, 1'b0, 1); step(rdy, w);
        set_req(2, 1'b1, 1'b1, 1'b0, 3); step(rdy, w);
        set_req(2, 1'b1, 1'b1, 1'b0, 4); step(rdy, w);
        set_req(2, 1'b1, 1'b1, 1'b0, 6); step(rdy, w);
        chk("pre_reset_q", 32'(q), 32'h5A);
        set_req(2, 1'b1, 1'b1, 1'b0, 0);
        set_req(3, 1'b1, 1'b1, 1'b0, 7);
        drive();
        #1;
        chk("pre_reset_ready", 32'(req_ready), 32'h8);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset_q", 32'(q), 32'h0);
        chk("mid_reset_ready", 32'(req_ready), 32'h0);
        chk("mid_reset_gv", 32'(grant_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_reset_q_edge", 32'(q), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(rdy, w);
        chk("post_reset_ready", 32'(rdy), 32'h4);
        chk("post_reset_gid", 32'(grant_id), 32'h2);
        chk("post_reset_q", 32'(q), 32'h01);

        // Randomized traffic against the model, with occasional resets.
        clear_reqs();
        do_reset();
        w = -1;
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!t_v[r] || (w == r)) begin
                    set_req(r, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 11)));
                end else if ($urandom_range(0, 15) == 0) begin
                    t_v[r] = 1'b0;
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                w = -1;
            end else begin
                step(rdy, w);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
